// File: rtl/vga_sync_capture.sv
// ---------------------------------------------------------------------------
// vga_sync_capture
//   Receive side of a VGA-style display link. Samples hsync/vsync/active/pixel
//   on the pixel clock, recovers (x, y) from the strobes and emits a write
//   stream into a frame buffer. By default the frame is decimated 2x2
//   (640x480 -> 320x240). Also checks geometry: per-line active length,
//   lines per frame, lock and a sticky error flag.
//
//   Build option: define CAPTURE_FULL_RES_EN to write every in-range active
//   pixel at full resolution instead of the 2x2 decimated frame.
//
// Ports
//   clk           pixel clock, rising edge
//   rst           asynchronous reset, active high
//   i_hsync       horizontal sync, asserted level = SYNC_POL
//   i_vsync       vertical sync, asserted level = SYNC_POL
//   i_active      display enable, active high
//   i_pixel       pixel data, qualified by i_active
//   o_wr_en       frame-buffer write strobe
//   o_wr_addr     frame-buffer word address
//   o_wr_data     frame-buffer write data
//   o_frame_done  one-cycle pulse when a captured frame closes
//   o_locked      last closed frame was exactly H_ACTIVE x V_ACTIVE
//   o_line_len    active-pixel count of the last finished line
//   o_err         sticky geometry error, cleared only by rst
// ---------------------------------------------------------------------------
module vga_sync_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter bit SYNC_POL = 1'b1,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_active,
  input  logic [DATA_W-1:0] i_pixel,
  output logic              o_wr_en,
  output logic [18:0]       o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_frame_done,
  output logic              o_locked,
  output logic [9:0]        o_line_len,
  output logic              o_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [9:0] H_A10   = 10'(H_ACTIVE);
  localparam logic [9:0] V_A10   = 10'(V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

`ifdef CAPTURE_FULL_RES_EN
  localparam logic [18:0] ROW_STEP = 19'(H_ACTIVE);
`else
  localparam logic [18:0] ROW_STEP = 19'(H_ACTIVE / 2);
`endif

  // -------------------------------------------------------------------------
  // Input stage. Sync levels are normalised to "1 = asserted" so the rest of
  // the design is polarity-agnostic.
  // -------------------------------------------------------------------------
  logic              r_s_hsync;
  logic              r_s_vsync;
  logic              r_d_vsync;
  logic              r_s_active;
  logic              r_d_active;
  logic [DATA_W-1:0] r_s_pixel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // vsync history resets to "asserted" so that releasing reset in the
      // middle of a sync pulse is not mistaken for a fresh frame start.
      r_s_hsync  <= 1'b0;
      r_s_vsync  <= 1'b1;
      r_d_vsync  <= 1'b1;
      r_s_active <= 1'b0;
      r_d_active <= 1'b0;
      r_s_pixel  <= '0;
    end else begin
      r_s_hsync  <= (i_hsync == SYNC_POL);
      r_s_vsync  <= (i_vsync == SYNC_POL);
      r_d_vsync  <= r_s_vsync;
      r_s_active <= i_active;
      r_d_active <= r_s_active;
      r_s_pixel  <= i_pixel;
    end
  end

  // Coordinates come entirely from active/vsync; hsync is sampled for
  // completeness of the input stage but carries nothing we need.
  logic w_unused_hsync;
  assign w_unused_hsync = r_s_hsync;

  logic w_vs_start;
  logic w_act_rise;
  logic w_line_end;

  assign w_vs_start = r_s_vsync & ~r_d_vsync;
  assign w_act_rise = r_s_active & ~r_d_active;
  assign w_line_end = r_d_active & ~r_s_active;

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_close;

  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_vs_start) w_state_nxt = ST_ARMED;
      ST_ARMED:   if (w_act_rise) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (w_vs_start) begin
          w_state_nxt = ST_ARMED;
          w_close     = 1'b1;
        end
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Coordinate counters and write decode
  // -------------------------------------------------------------------------
  logic [9:0]  r_x_cnt;
  logic [9:0]  r_y_cnt;
  logic [18:0] r_row_base;
  logic        r_frame_bad;

  logic        w_in_cap;
  logic        w_px;
  logic        w_le_cap;
  logic        w_line_bad;
  logic [9:0]  w_y_final;
  logic        w_in_range;
  logic        w_wr;
  logic [18:0] w_addr;
  logic        w_row_adv;

  assign w_in_cap = (r_state == ST_CAPTURE);

  // A pixel belongs to the frame once capture is running, including the very
  // first active cycle that moves ARMED -> CAPTURE. Anything seen in IDLE is
  // ignored entirely.
  assign w_px = r_s_active & (w_in_cap | ((r_state == ST_ARMED) & w_act_rise));

  assign w_le_cap   = w_line_end & w_in_cap;
  assign w_line_bad = w_le_cap & (r_x_cnt != H_A10);

  // A line ending on the same cycle as the frame close still counts.
  assign w_y_final  = (w_le_cap && (r_y_cnt != CNT_MAX)) ? r_y_cnt + 10'd1 : r_y_cnt;

  assign w_in_range = (r_x_cnt < H_A10) & (r_y_cnt < V_A10);

`ifdef CAPTURE_FULL_RES_EN
  assign w_wr      = w_px & w_in_range;
  assign w_addr    = r_row_base + {9'd0, r_x_cnt};
  assign w_row_adv = w_le_cap;
`else
  assign w_wr      = w_px & w_in_range & ~r_x_cnt[0] & ~r_y_cnt[0];
  assign w_addr    = r_row_base + {10'd0, r_x_cnt[9:1]};
  // Only even source lines start a new decimated row.
  assign w_row_adv = w_le_cap & ~r_y_cnt[0];
`endif

  // -------------------------------------------------------------------------
  // State, counters, status and output registers
  // -------------------------------------------------------------------------
  logic              r_wr_en;
  logic [18:0]       r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_frame_done;
  logic              r_locked;
  logic [9:0]        r_line_len;
  logic              r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_row_base   <= '0;
      r_frame_bad  <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_locked     <= 1'b0;
      r_line_len   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // x: counts active cycles of the current line, saturating
      if (w_line_end)
        r_x_cnt <= '0;
      else if (w_px && (r_x_cnt != CNT_MAX))
        r_x_cnt <= r_x_cnt + 10'd1;

      // y / row base: lines of the current frame
      if (w_close) begin
        r_y_cnt    <= '0;
        r_row_base <= '0;
      end else begin
        if (w_le_cap && (r_y_cnt != CNT_MAX))
          r_y_cnt <= r_y_cnt + 10'd1;
        if (w_row_adv)
          r_row_base <= r_row_base + ROW_STEP;
      end

      // Output write stage: one register after the input register.
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= w_addr;
        r_wr_data <= r_s_pixel;
      end

      if (w_le_cap)
        r_line_len <= r_x_cnt;

      if (w_line_bad || (w_close && (w_y_final != V_A10)))
        r_err <= 1'b1;

      r_frame_done <= w_close;

      if (w_close) begin
        r_locked    <= ~(r_frame_bad | w_line_bad | (w_y_final != V_A10));
        r_frame_bad <= 1'b0;
      end else if (w_line_bad) begin
        r_frame_bad <= 1'b1;
      end
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_frame_done = r_frame_done;
  assign o_locked     = r_locked;
  assign o_line_len   = r_line_len;
  assign o_err        = r_err;

endmodule

// File: tb/tb_vga_sync_capture.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_capture
//   Directed bench on a reduced 16x8 active geometry (25-cycle lines, 12-line
//   frames). Two instances share one stimulus: u_dut_p with active-high syncs
//   and u_dut_n with active-low syncs driven by inverted sync lines, so both
//   must produce the same write stream. Expected writes are queued by the
//   driver from the pixel coordinates it drives, stamped with the drive
//   cycle; each DUT write must match address, data and arrive 2 cycles later.
// ---------------------------------------------------------------------------
module tb_vga_sync_capture;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int DW = 12;

`ifdef CAPTURE_FULL_RES_EN
  localparam int NW    = H * V;           // 128 writes per good frame
  localparam int NW2   = H * V - 1;       // frame with one 15-pixel line
  localparam int LASTA = 127;
  localparam int LASTD = (15 << 6) | 7;   // pixel(15,7)
`else
  localparam int NW    = H * V / 4;       // 32 writes per good frame
  localparam int NW2   = H * V / 4;       // dropped pixel is odd x
  localparam int LASTA = 31;
  localparam int LASTD = (14 << 6) | 6;   // pixel(14,6)
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hs = 1'b0, hs_n = 1'b1, vs = 1'b0, vs_n = 1'b1, act = 1'b0;
  logic [DW-1:0] pix = '0;

  logic          wr1, fd1, lk1, er1, wr2, fd2, lk2, er2;
  logic [18:0]   ad1, ad2;
  logic [DW-1:0] dt1, dt2;
  logic [9:0]    ll1, ll2;

  always #5 clk = ~clk;

  vga_sync_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_POL(1'b1), .DATA_W(DW)) u_dut_p (
    .clk(clk), .rst(rst), .i_hsync(hs), .i_vsync(vs), .i_active(act), .i_pixel(pix),
    .o_wr_en(wr1), .o_wr_addr(ad1), .o_wr_data(dt1), .o_frame_done(fd1),
    .o_locked(lk1), .o_line_len(ll1), .o_err(er1));

  vga_sync_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_POL(1'b0), .DATA_W(DW)) u_dut_n (
    .clk(clk), .rst(rst), .i_hsync(hs_n), .i_vsync(vs_n), .i_active(act), .i_pixel(pix),
    .o_wr_en(wr2), .o_wr_addr(ad2), .o_wr_data(dt2), .o_frame_done(fd2),
    .o_locked(lk2), .o_line_len(ll2), .o_err(er2));

  typedef struct {
    integer addr;
    integer data;
    integer cyc;
  } exp_t;

  exp_t   q1[$], q2[$];
  exp_t   e1, e2;
  integer cyc = 0;
  integer tests = 0, fails = 0;
  integer nwr1 = 0, nwr2 = 0, ndone1 = 0, ndone2 = 0;
  integer la1 = -1, ld1 = -1, la2 = -1, ld2 = -1;
  integer b1, b2;
  bit     cap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input integer obs, input integer exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Write/pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr1 === 1'b1) begin
      nwr1++;
      la1 = integer'(ad1);
      ld1 = integer'(dt1);
      chk("wr_p_expected", integer'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("wr_p_addr", integer'(ad1), e1.addr);
        chk("wr_p_data", integer'(dt1), e1.data);
        chk("wr_p_latency", cyc, e1.cyc + 2);
      end
    end
    if (wr2 === 1'b1) begin
      nwr2++;
      la2 = integer'(ad2);
      ld2 = integer'(dt2);
      chk("wr_n_expected", integer'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        chk("wr_n_addr", integer'(ad2), e2.addr);
        chk("wr_n_data", integer'(dt2), e2.data);
        chk("wr_n_latency", cyc, e2.cyc + 2);
      end
    end
    if (fd1 === 1'b1) ndone1++;
    if (fd2 === 1'b1) ndone2++;
  end

  function automatic logic [DW-1:0] pixv(input int x, input int y);
    logic [5:0] xl, yl;
    xl = x[5:0];
    yl = y[5:0];
    return {xl, yl};
  endfunction

  task automatic cyc1(input bit h, input bit v, input bit a, input logic [DW-1:0] p);
    @(posedge clk);
    #1;
    hs = h; hs_n = ~h; vs = v; vs_n = ~v; act = a; pix = p;
  endtask

  // One line: 4 hsync, 2 back porch, npix active (padded to H), 3 front porch.
  task automatic drive_line(input bit v, input int y, input int npix);
    exp_t e;
    int   pad;
    for (int i = 0; i < 4; i++) cyc1(1'b1, v, 1'b0, '0);
    for (int i = 0; i < 2; i++) cyc1(1'b0, v, 1'b0, '0);
    if (y >= 0) begin
      for (int x = 0; x < npix; x++) begin
        cyc1(1'b0, v, 1'b1, pixv(x, y));
`ifdef CAPTURE_FULL_RES_EN
        if (cap) begin
          e.addr = y * H + x;
`else
        if (cap && (x % 2 == 0) && (y % 2 == 0)) begin
          e.addr = (y / 2) * (H / 2) + x / 2;
`endif
          e.data = integer'(pixv(x, y));
          e.cyc  = cyc;
          q1.push_back(e);
          q2.push_back(e);
        end
      end
    end
    pad = ((y >= 0) ? (H - npix) : H) + 3;
    for (int i = 0; i < pad; i++) cyc1(1'b0, v, 1'b0, '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   integer'(wr1), 0);
    chk({tag, "_addr"},    integer'(ad1), 0);
    chk({tag, "_data"},    integer'(dt1), 0);
    chk({tag, "_done"},    integer'(fd1), 0);
    chk({tag, "_locked"},  integer'(lk1), 0);
    chk({tag, "_linelen"}, integer'(ll1), 0);
    chk({tag, "_err"},     integer'(er1), 0);
    chk({tag, "_n_locked"},  integer'(lk2), 0);
    chk({tag, "_n_linelen"}, integer'(ll2), 0);
    chk({tag, "_n_err"},     integer'(er2), 0);
  endtask

  // Frame: 2 vsync lines, 1 blank, V active lines, 1 blank.
  task automatic drive_frame(input int bad_y, input int rst_y);
    drive_line(1'b1, -1, 0);
    drive_line(1'b1, -1, 0);
    drive_line(1'b0, -1, 0);
    for (int y = 0; y < V; y++) begin
      if (y == rst_y) begin
        chk("prerst_locked", integer'(lk1), 1);
        chk("prerst_err", integer'(er1), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cap = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      drive_line(1'b0, y, (y == bad_y) ? H - 1 : H);
      if (y == bad_y) begin
        chk("badline_len", integer'(ll1), H - 1);
        chk("badline_err", integer'(er1), 1);
        chk("badline_n_len", integer'(ll2), H - 1);
      end
    end
    drive_line(1'b0, -1, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Active pulses before any vsync: must be ignored
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 5; k++) cyc1(1'b0, 1'b0, 1'b1, pixv(k + 1, i + 1));
      for (int k = 0; k < 3; k++) cyc1(1'b0, 1'b0, 1'b0, '0);
    end
    chk("idle_writes_p", nwr1, 0);
    chk("idle_writes_n", nwr2, 0);

    // Frame 1: good
    cap = 1'b1;
    b1 = nwr1; b2 = nwr2;
    drive_frame(-1, -1);
    chk("f1_writes_p", nwr1 - b1, NW);
    chk("f1_writes_n", nwr2 - b2, NW);
    chk("f1_last_addr", la1, LASTA);
    chk("f1_last_data", ld1, LASTD);
    chk("f1_n_last_addr", la2, LASTA);
    chk("f1_done_open", ndone1, 0);
    chk("f1_locked_open", integer'(lk1), 0);
    chk("f1_line_len", integer'(ll1), H);
    chk("f1_err", integer'(er1), 0);

    // Frame 2: line 4 one pixel short (closes frame 1)
    b1 = nwr1; b2 = nwr2;
    drive_frame(4, -1);
    chk("f2_writes_p", nwr1 - b1, NW2);
    chk("f2_writes_n", nwr2 - b2, NW2);
    chk("f1_done", ndone1, 1);
    chk("f1_n_done", ndone2, 1);
    chk("f1_locked", integer'(lk1), 1);
    chk("f1_n_locked", integer'(lk2), 1);
    chk("f2_line_len_after", integer'(ll1), H);
    chk("f2_err_sticky", integer'(er1), 1);

    // Frame 3: good (closes frame 2 -> unlocked)
    drive_frame(-1, -1);
    chk("f2_done", ndone1, 2);
    chk("f2_locked", integer'(lk1), 0);
    chk("f2_n_locked", integer'(lk2), 0);
    chk("f3_err_sticky", integer'(er1), 1);

    // Frame 4: closes frame 3, then reset at line 4
    b1 = nwr1; b2 = nwr2;
    drive_frame(-1, 4);
    chk("f4_writes_p", nwr1 - b1, NW / 2);
    chk("f4_writes_n", nwr2 - b2, NW / 2);
    chk("f3_done", ndone1, 3);
    chk("f4_locked_after_rst", integer'(lk1), 0);
    chk("f4_err_after_rst", integer'(er1), 0);
    chk("f4_queue_empty", q1.size(), 0);

    // Frame 5: captured again from address 0
    cap = 1'b1;
    b1 = nwr1; b2 = nwr2;
    drive_frame(-1, -1);
    chk("f5_writes_p", nwr1 - b1, NW);
    chk("f5_writes_n", nwr2 - b2, NW);
    chk("f5_last_addr", la1, LASTA);
    chk("f5_last_data", ld1, LASTD);
    chk("f4_no_done", ndone1, 3);

    // Next vsync closes frame 5
    drive_line(1'b1, -1, 0);
    drive_line(1'b1, -1, 0);
    chk("f5_done", ndone1, 4);
    chk("f5_n_done", ndone2, 4);
    chk("f5_locked", integer'(lk1), 1);
    chk("f5_n_locked", integer'(lk2), 1);
    chk("f5_err", integer'(er1), 0);
    chk("final_queue_p", q1.size(), 0);
    chk("final_queue_n", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
